// File: rtl/global_buffer_banked.sv
// rtl/global_buffer_banked.sv - multi-ported, word-interleaved banked global buffer
// Per-bank round-robin arbitration, byte-lane writes, out-of-range flagging, saturating stall counter.
module global_buffer_banked #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int NUM_BANKS = 4,
  parameter int NUM_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] be,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [NUM_PORTS*DATA_W-1:0]   rdata,
  output logic [NUM_PORTS-1:0]          err,
  output logic [15:0]                   stall_cnt
);

  localparam int LANES = DATA_W / 8;
  localparam int BB    = $clog2(NUM_BANKS);
  localparam int DB    = $clog2(DEPTH);
  localparam int ROWS  = DEPTH / NUM_BANKS;
  localparam int BW    = (BB > 0) ? BB : 1;
  localparam int RW    = (DB - BB > 0) ? DB - BB : 1;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [DATA_W-1:0]                 mem_q [NUM_BANKS][ROWS];
  logic [BW-1:0]                     bank_a [NUM_PORTS];
  logic [RW-1:0]                     row_a [NUM_PORTS];
  logic [NUM_PORTS-1:0]              oob;
  logic [NUM_BANKS-1:0][PW-1:0]      rr_q, rr_d;
  logic [NUM_PORTS-1:0]              rvalid_q, err_q;
  logic [NUM_PORTS*DATA_W-1:0]       rdata_q;
  logic [15:0]                       stall_q, stall_d;

  always_comb begin
    logic [ADDR_W-1:0] a;
    a = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      a         = addr[p*ADDR_W +: ADDR_W];
      bank_a[p] = BW'(a & ADDR_W'(NUM_BANKS - 1));
      row_a[p]  = RW'((a & ADDR_W'(DEPTH - 1)) >> BB);
      oob[p]    = (a >> DB) != '0;
    end
  end

  // Out-of-range requests never reach a bank, so they are granted unconditionally.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    gnt   = req & oob;
    rr_d  = rr_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      found = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = int'(rr_q[b]) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!found && req[idx] && !oob[idx] && int'(bank_a[idx]) == b) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          rr_d[b]  = (idx == NUM_PORTS - 1) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (|(req & ~gnt) && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p] && we[p] && !oob[p]) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[p*LANES + i])
            mem_q[bank_a[p]][row_a[p]][i*8 +: 8] <= wdata[p*DATA_W + i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      stall_q  <= '0;
    end else begin
      rr_q     <= rr_d;
      rvalid_q <= gnt & ~we;
      err_q    <= gnt & oob;
      stall_q  <= stall_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gnt[p] && !we[p])
          rdata_q[p*DATA_W +: DATA_W] <= oob[p] ? '0 : mem_q[bank_a[p]][row_a[p]];
      end
    end
  end

  assign rvalid    = rvalid_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_global_buffer_banked.sv
// tb/tb_global_buffer_banked.sv - scoreboard bench for global_buffer_banked
// Flat-memory reference model; a monitor pops expected responses each cycle.
module tb_global_buffer_banked;
  localparam int DW = 16, AW = 32, DEPTH = 1024, NB = 4, NP = 2, NL = DW / 8;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NP-1:0]     req = '0, we = '0, gnt, rvalid, err;
  logic [NP*AW-1:0]  addr = '0;
  logic [NP*DW-1:0]  wdata = '0, rdata;
  logic [NP*NL-1:0]  be = '0;
  logic [15:0]       stall_cnt;

  always #5 clk = ~clk;

  global_buffer_banked #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_BANKS(NB), .NUM_PORTS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err), .stall_cnt(stall_cnt)
  );

  typedef struct { logic rv; logic er; logic [DW-1:0] d; } resp_t;
  resp_t          expq [NP][$];
  logic [DW-1:0]  mm [DEPTH];
  int             rr_m [NB];
  int             stall_m;
  logic [DW-1:0]  last_rd [NP];
  int             rv_cnt [NP];
  logic [NP-1:0]  mg;
  logic [1:0]     conf_exp [4];
  int             errors = 0, checks = 0;
  bit             done = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NL-1:0] b);
    req[p] = r;
    we[p]  = w;
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
    be[p*NL +: NL] = b;
  endtask

  task automatic idle();
    req = '0;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) rr_m[b] = 0;
    for (int p = 0; p < NP; p++) begin
      last_rd[p] = '0;
      expq[p].delete();
    end
    stall_m = 0;
    mg = '0;
  endtask

  // Evaluate the reference model for the current inputs, then advance one clock.
  task automatic step();
    logic [AW-1:0] a;
    bit found;
    int p;
    #1;
    mg = '0;
    for (int q = 0; q < NP; q++)
      if (req[q] && addr[q*AW +: AW] >= DEPTH) mg[q] = 1'b1;
    for (int b = 0; b < NB; b++) begin
      found = 0;
      for (int k = 0; k < NP; k++) begin
        p = (rr_m[b] + k) % NP;
        a = addr[p*AW +: AW];
        if (!found && req[p] && a < DEPTH && (a % NB) == b) begin
          found = 1;
          mg[p] = 1'b1;
          rr_m[b] = (p + 1) % NP;
        end
      end
    end
    chk("gnt", gnt, mg);
    if (|(req & ~mg) && stall_m < 65535) stall_m++;
    for (int q = 0; q < NP; q++) begin
      if (mg[q]) begin
        a = addr[q*AW +: AW];
        if (a >= DEPTH) expq[q].push_back('{rv: ~we[q], er: 1'b1, d: '0});
        else if (we[q]) begin
          for (int i = 0; i < NL; i++)
            if (be[q*NL + i]) mm[a][i*8 +: 8] = wdata[q*DW + i*8 +: 8];
        end else expq[q].push_back('{rv: 1'b1, er: 1'b0, d: mm[a]});
      end
    end
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    resp_t e;
    bit has;
    forever begin
      @(negedge clk);
      #1;
      if (!done) begin
        for (int p = 0; p < NP; p++) begin
          has = expq[p].size() > 0;
          chk($sformatf("resp_present_p%0d", p), {31'd0, rvalid[p] | err[p]}, {31'd0, has});
          if (has && (rvalid[p] || err[p])) begin
            e = expq[p].pop_front();
            chk($sformatf("rvalid_p%0d", p), {31'd0, rvalid[p]}, {31'd0, e.rv});
            chk($sformatf("err_p%0d", p), {31'd0, err[p]}, {31'd0, e.er});
            if (e.rv) begin
              last_rd[p] = e.d;
              rv_cnt[p]++;
            end
          end else if (has) expq[p].delete();
          chk($sformatf("rdata_p%0d", p), rdata[p*DW +: DW], last_rd[p]);
        end
        chk("stall_cnt", stall_cnt, stall_m);
      end
    end
  end

  initial begin
    int c0, c1;
    logic [AW-1:0] a;
    int sel;
    conf_exp[0] = 2'b01; conf_exp[1] = 2'b10; conf_exp[2] = 2'b01; conf_exp[3] = 2'b10;
    for (int p = 0; p < NP; p++) rv_cnt[p] = 0;
    model_reset();
    @(negedge clk);
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;

    set_port(0, 1, 1, 5, 16'hBEEF, 2'b11); step();
    set_port(0, 1, 0, 5, 16'h0000, 2'b00); step();
    chk("beef_rvalid", rvalid[0], 1);
    chk("beef_err", err[0], 0);
    chk("beef_rdata", rdata[DW-1:0], 16'hBEEF);
    idle(); step();

    set_port(0, 1, 1, 8, 16'h1234, 2'b11); step();
    set_port(0, 1, 1, 8, 16'hAB00, 2'b10); step();
    set_port(0, 1, 0, 8, 16'h0000, 2'b00); step();
    chk("lanes_rdata", rdata[DW-1:0], 16'hAB34);
    idle(); step();

    for (int i = 0; i < 32; i++) begin
      set_port(0, 1, 1, i, DW'($urandom), 2'b11); step();
    end
    idle(); step();
    do_reset();

    c0 = rv_cnt[0]; c1 = rv_cnt[1];
    set_port(0, 1, 0, 0, 0, 0);
    set_port(1, 1, 0, 4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("conflict_gnt", gnt, conf_exp[i]);
      step();
    end
    chk("conflict_stall", stall_cnt, 4);
    idle(); step();
    chk("conflict_rv0", rv_cnt[0] - c0, 2);
    chk("conflict_rv1", rv_cnt[1] - c1, 2);

    set_port(0, 1, 0, 1, 0, 0);
    set_port(1, 1, 1, 2, 16'hC0DE, 2'b11);
    #1 chk("parallel_gnt", gnt, 2'b11);
    step();
    idle(); step();
    chk("parallel_stall", stall_cnt, 4);

    set_port(1, 1, 0, 1024, 0, 0); step();
    chk("oob_rvalid", rvalid[1], 1);
    chk("oob_err", err[1], 1);
    chk("oob_rdata", rdata[2*DW-1:DW], 0);
    idle();
    set_port(0, 1, 1, 32'h10000, 16'h5A5A, 2'b11); step();
    chk("oobw_err", err[0], 1);
    chk("oobw_rvalid", rvalid[0], 0);
    set_port(0, 1, 0, 0, 0, 0); step();
    chk("oobw_nowrite", rdata[DW-1:0], mm[0]);
    idle(); step();

    set_port(0, 1, 0, 3, 0, 0);
    #1 chk("rstmid_gnt", gnt[0], 1);
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    chk("rstmid_rvalid", rvalid, 0);
    chk("rstmid_stall", stall_cnt, 0);
    set_port(0, 1, 0, 1, 0, 0);
    set_port(1, 1, 0, 5, 0, 0);
    #1 chk("rstmid_rr", gnt, 2'b01);
    step();
    idle(); step(); step();

    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req[p] || mg[p]) begin
          sel = $urandom % 16;
          if (sel == 0) a = DEPTH + ($urandom % 64);
          else if (sel == 1) a = 32'hFFFF0000 + ($urandom % 16);
          else a = $urandom % 32;
          set_port(p, ($urandom % 4) != 0, 1'($urandom), a, DW'($urandom), NL'($urandom));
        end else if ($urandom % 8 == 0) req[p] = 1'b0;
      end
      step();
    end
    idle(); step(); step();

    set_port(0, 1, 1, 0, 0, 0);
    set_port(1, 1, 1, 4, 0, 0);
    repeat (65540) step();
    chk("stall_saturate", stall_cnt, 16'hFFFF);
    idle(); step();
    chk("stall_hold", stall_cnt, 16'hFFFF);

    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/global_buffer_banked.md
# global_buffer_banked

Parametrised, multi-ported successor to the single-port on-chip global buffer. It holds DEPTH words of DATA_W bits split across NUM_BANKS word-interleaved SRAM banks. NUM_PORTS independent requesters (DMA, PE-array feeders, writeback) can each issue one access per cycle, with per-bank round-robin arbitration, byte-lane write enables, out-of-range detection and a saturating stall counter.

## Interface
- DATA_W, 16: word width; multiple of 8.
- ADDR_W, 32: word-address width per port.
- DEPTH, 1024: total words; power of 2.
- NUM_BANKS, 4: banks; power of 2, ≤ DEPTH.
- NUM_PORTS, 2: requester ports, ≥ 1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_PORTS  per-port request.
- we  in  NUM_PORTS  per-port write (1) / read (0).
- addr  in  NUM_PORTS*ADDR_W  word addresses, port p at [p*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*DATA_W  write data.
- be  in  NUM_PORTS*DATA_W/8  byte-lane write enables, bit 0 = bits [7:0].
- gnt  out  NUM_PORTS  combinational grant; request accepted at this edge.
- rvalid  out  NUM_PORTS  read data valid, one-cycle pulse.
- rdata  out  NUM_PORTS*DATA_W  registered read data.
- err  out  NUM_PORTS  out-of-range pulse, aligned with the response slot.
- stall_cnt  out  16  saturating count of cycles with ≥1 denied request.

## Operation
- Decode: bank = addr[BB-1:0], row = addr[DB-1:BB], with BB = log2(NUM_BANKS) and DB = log2(DEPTH). Out-of-range (oob) when addr[ADDR_W-1:DB] ≠ 0.
- Arbitration: each bank has a round-robin pointer rr[b] (reset 0). Among in-range requesters to bank b, grant the first port at or after rr[b], scanning upward and wrapping. On a grant, rr[b] ← granted port + 1 mod NUM_PORTS. Banks without a grant keep their pointer.
- oob requests bypass arbitration: always granted, never touch memory.
- Requester holds req/we/addr/wdata/be stable until gnt. It may deassert req earlier (request withdrawn, nothing happens).
- Write: on the grant edge, each lane i with be[i]=1 is written and other lanes keep their old value. be = 0 is legal, a no-op write. No response.
- Read: on the grant edge, rdata[p] ← bank word, and rvalid[p]=1 in the next cycle. rdata[p] holds until the next read response on that port.
- oob read: rvalid[p]=1 and err[p]=1 next cycle, rdata[p] ← 0. oob write: err[p]=1 next cycle, memory unchanged, rvalid stays 0.
- Only one port can be granted per bank per cycle, so there is no same-bank read/write collision. Different banks proceed in parallel.
- stall_cnt increments when any req[p]=1 with gnt[p]=0. It saturates at 0xFFFF.
- Memory contents are not reset.

## Timing
- Reset values: gnt follows inputs (all 0 while req=0); rvalid=0, rdata=0, err=0, stall_cnt=0, all rr=0.
- Reset asserted mid-operation: pending responses are dropped (rvalid/err forced 0). A write on the reset-assertion edge is not guaranteed.
- Grant latency 0 cycles (combinational). Read latency 1 cycle after the grant edge.
- Throughput: 1 access/port/cycle without conflicts. Under a persistent k-way conflict, each contender is granted once every k cycles.
- Read-after-write: a same-port read granted in the cycle after a write returns the new data. A read granted in the same cycle as another port's write can only target a different bank.
- No combinational path from req to rvalid/rdata.

## Test plan
- Reset, then port 0 writes 0xBEEF at addr 5 with be=11, then reads addr 5: gnt[0] same cycle; one cycle later rvalid[0]=1, rdata[0]=0xBEEF, err=0.
- Byte lanes: write 0x1234 at addr 8 with be=11, then 0xAB00 with be=10, read addr 8 → 0xAB34.
- Conflict: ports 0 and 1 both read bank 0 (addrs 0, 4) every cycle for 4 cycles: gnt = 01,10,01,10; stall_cnt = 4; each port sees 2 rvalid pulses.
- Parallel: port 0 reads addr 1 (bank 1) while port 1 writes addr 2 (bank 2): both granted, stall_cnt unchanged.
- Out of range: port 1 reads addr 1024: gnt[1]=1, next cycle rvalid[1]=1, err[1]=1, rdata[1]=0. A write to 0x10000 sets err only, and memory is unchanged.
- rst_n low for 1 cycle right after a read grant: rvalid stays 0, and stall_cnt and rr return to 0.
